// File: rtl/car_cmd_executor.sv
// Car-side command executor: qualifies the controller's latched 3-bit code on a slow tick
// and runs one timed manoeuvre (forward or spin turn, then brake) on a dual H-bridge.
module car_cmd_executor #(
    parameter int TICK_DIV     = 65536,
    parameter int STABLE_TICKS = 4,
    parameter int FWD_TICKS    = 1524,
    parameter int TURN_TICKS   = 762,
    parameter int BRAKE_TICKS  = 76,
    parameter int PWM_BITS     = 8,
    parameter int DUTY         = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cmd_in,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       busy,
    output logic       cmd_ack,
    output logic       cmd_err,
    output logic [1:0] state_o
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_A  = (FWD_TICKS > TURN_TICKS) ? FWD_TICKS : TURN_TICKS;
    localparam int MAX_B  = (BRAKE_TICKS > STABLE_TICKS) ? BRAKE_TICKS : STABLE_TICKS;
    localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_T) + 1;
    localparam int PWM_W1 = PWM_BITS + 1;

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  STABLE_C   = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0]  FWD_LOAD   = CNT_W'(FWD_TICKS - 1);
    localparam logic [CNT_W-1:0]  TURN_LOAD  = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0]  BRAKE_LOAD = CNT_W'(BRAKE_TICKS - 1);
    localparam logic [PWM_W1-1:0] DUTY_C     = PWM_W1'(DUTY);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FWD   = 2'b01;
    localparam logic [1:0] ST_TURN  = 2'b10;
    localparam logic [1:0] ST_BRAKE = 2'b11;

    logic [2:0]          cmd_m_q, cmd_m_d, cmd_s_q, cmd_s_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [2:0]          last_q, last_d;
    logic [CNT_W-1:0]    stab_q, stab_d;
    logic                armed_q, armed_d;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [1:0]          motor_l_q, motor_l_d, motor_r_q, motor_r_d;
    logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
    logic                busy_q, busy_d, ack_q, ack_d, err_q, err_d;
    logic [1:0]          state_o_q, state_o_d;

    logic tick_s, same_s, qualify_s, honour_s, go_fwd_s, go_turn_s, bad_s, pwm_raw_s;

    // Synchroniser, prescaler and free-running PWM counter
    always_comb begin
        cmd_m_d   = cmd_in;
        cmd_s_d   = cmd_m_q;
        tick_s    = (pre_q == PRE_LAST);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_raw_s = ({1'b0, pwm_cnt_q} < DUTY_C);
        if (tick_s) begin
            pre_d = {PRE_W{1'b0}};
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Qualifier: qualify fires only on the tick where the run length first reaches STABLE_TICKS
    always_comb begin
        same_s    = (cmd_s_q == last_q) && (cmd_s_q != 3'b000);
        last_d    = last_q;
        stab_d    = stab_q;
        qualify_s = 1'b0;
        if (tick_s) begin
            if (same_s) begin
                if (stab_q < STABLE_C) begin
                    stab_d = stab_q + CNT_W'(1);
                end else begin
                    stab_d = stab_q;
                end
            end else begin
                last_d = cmd_s_q;
                stab_d = (cmd_s_q != 3'b000) ? CNT_W'(1) : {CNT_W{1'b0}};
            end
            qualify_s = (stab_d == STABLE_C) && !(same_s && (stab_q == STABLE_C));
        end else begin
            qualify_s = 1'b0;
        end
    end

    // Acceptance, arming and manoeuvre sequencing
    always_comb begin
        honour_s  = qualify_s && armed_q && (state_q == ST_IDLE);
        go_fwd_s  = honour_s && (cmd_s_q == 3'b001);
        go_turn_s = honour_s && (cmd_s_q == 3'b010);
        bad_s     = honour_s && !go_fwd_s && !go_turn_s;
        if (honour_s) begin
            armed_d = 1'b0;
        end else if (tick_s && (cmd_s_q == 3'b000)) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (go_fwd_s) begin
                    state_d = ST_FWD;
                    timer_d = FWD_LOAD;
                end else if (go_turn_s) begin
                    state_d = ST_TURN;
                    timer_d = TURN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD, ST_TURN: begin
                if (tick_s && (timer_q == {CNT_W{1'b0}})) begin
                    state_d = ST_BRAKE;
                    timer_d = BRAKE_LOAD;
                end else if (tick_s) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_BRAKE: begin
                if (tick_s && (timer_q == {CNT_W{1'b0}})) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Bridge drive decode; registered below so outputs lag state by one clk
    always_comb begin
        busy_d    = (state_q != ST_IDLE);
        state_o_d = state_q;
        ack_d     = go_fwd_s || go_turn_s;
        err_d     = bad_s;
        case (state_q)
            ST_FWD: begin
                motor_l_d = 2'b10;
                motor_r_d = 2'b10;
                pwm_l_d   = pwm_raw_s;
                pwm_r_d   = pwm_raw_s;
            end
            ST_TURN: begin
                motor_l_d = 2'b01;
                motor_r_d = 2'b10;
                pwm_l_d   = pwm_raw_s;
                pwm_r_d   = pwm_raw_s;
            end
            ST_BRAKE: begin
                motor_l_d = 2'b11;
                motor_r_d = 2'b11;
                pwm_l_d   = 1'b1;
                pwm_r_d   = 1'b1;
            end
            default: begin
                motor_l_d = 2'b00;
                motor_r_d = 2'b00;
                pwm_l_d   = 1'b0;
                pwm_r_d   = 1'b0;
            end
        endcase
    end

    // State registers; armed comes out of reset set so the first command is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_m_q   <= 3'b000;
            cmd_s_q   <= 3'b000;
            pre_q     <= {PRE_W{1'b0}};
            last_q    <= 3'b000;
            stab_q    <= {CNT_W{1'b0}};
            armed_q   <= 1'b1;
            state_q   <= ST_IDLE;
            timer_q   <= {CNT_W{1'b0}};
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            motor_l_q <= 2'b00;
            motor_r_q <= 2'b00;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            state_o_q <= 2'b00;
        end else begin
            cmd_m_q   <= cmd_m_d;
            cmd_s_q   <= cmd_s_d;
            pre_q     <= pre_d;
            last_q    <= last_d;
            stab_q    <= stab_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            pwm_cnt_q <= pwm_cnt_d;
            motor_l_q <= motor_l_d;
            motor_r_q <= motor_r_d;
            pwm_l_q   <= pwm_l_d;
            pwm_r_q   <= pwm_r_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            state_o_q <= state_o_d;
        end
    end

    assign motor_l = motor_l_q;
    assign motor_r = motor_r_q;
    assign pwm_l   = pwm_l_q;
    assign pwm_r   = pwm_r_q;
    assign busy    = busy_q;
    assign cmd_ack = ack_q;
    assign cmd_err = err_q;
    assign state_o = state_o_q;

endmodule

// File: tb/tb_car_cmd_executor.sv
// Bench for car_cmd_executor: directed scenarios plus random holds, every clk compared
// against a tick-level behavioural model of the command rules.
module tb_car_cmd_executor;

    localparam int TICK_DIV = 4;
    localparam int STABLE   = 3;
    localparam int FWD      = 5;
    localparam int TURN     = 3;
    localparam int BRAKE    = 2;
    localparam int DUTY     = 192;

    localparam int P_IDLE  = 0;
    localparam int P_FWD   = 1;
    localparam int P_TURN  = 2;
    localparam int P_BRAKE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] cmd_in = 3'b000;
    logic [1:0] motor_l, motor_r, state_o;
    logic       pwm_l, pwm_r, busy, cmd_ack, cmd_err;

    int checks = 0;
    int errors = 0;

    // model state
    int         k;
    logic [2:0] h1, h2, m_last;
    int         m_run, m_phase, m_rem;
    bit         m_armed;

    // observed counters for scenario-level checks
    int n_ack, n_err, n_fwd, n_turn, n_brake, n_busy;

    car_cmd_executor #(
        .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE), .FWD_TICKS(FWD),
        .TURN_TICKS(TURN), .BRAKE_TICKS(BRAKE), .PWM_BITS(8), .DUTY(DUTY)
    ) dut (
        .clk(clk), .reset(reset), .cmd_in(cmd_in),
        .motor_l(motor_l), .motor_r(motor_r), .pwm_l(pwm_l), .pwm_r(pwm_r),
        .busy(busy), .cmd_ack(cmd_ack), .cmd_err(cmd_err), .state_o(state_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; h1 = 3'b000; h2 = 3'b000; m_last = 3'b000;
        m_run = 0; m_phase = P_IDLE; m_rem = 0; m_armed = 1'b1;
    endtask

    task automatic clr_counts();
        n_ack = 0; n_err = 0; n_fwd = 0; n_turn = 0; n_brake = 0; n_busy = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_motor_l"}, 32'(motor_l), 32'd0);
        chk({tag, "_motor_r"}, 32'(motor_r), 32'd0);
        chk({tag, "_pwm"},     32'({pwm_l, pwm_r}), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_state_o"}, 32'(state_o), 32'd0);
        chk({tag, "_ackerr"},  32'({cmd_ack, cmd_err}), 32'd0);
    endtask

    // one clk: drive v, advance the model over this edge, compare every output
    task automatic step(input logic [2:0] v);
        logic [1:0] e_ml, e_mr, e_st;
        logic       e_pl, e_pr, raw;
        bit         ack_now, err_now;
        logic [2:0] s;
        cmd_in = v;
        @(posedge clk);
        raw = ((k % 256) < DUTY);
        case (m_phase)
            P_FWD:   begin e_ml = 2'b10; e_mr = 2'b10; e_pl = raw;  e_pr = raw;  e_st = 2'b01; end
            P_TURN:  begin e_ml = 2'b01; e_mr = 2'b10; e_pl = raw;  e_pr = raw;  e_st = 2'b10; end
            P_BRAKE: begin e_ml = 2'b11; e_mr = 2'b11; e_pl = 1'b1; e_pr = 1'b1; e_st = 2'b11; end
            default: begin e_ml = 2'b00; e_mr = 2'b00; e_pl = 1'b0; e_pr = 1'b0; e_st = 2'b00; end
        endcase
        ack_now = 1'b0; err_now = 1'b0;
        if ((k % TICK_DIV) == TICK_DIV - 1) begin
            s = h2;
            if (s != 3'b000 && s == m_last) m_run++;
            else begin m_last = s; m_run = (s != 3'b000) ? 1 : 0; end
            if (s == 3'b000) m_armed = 1'b1;
            if (m_phase != P_IDLE) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_phase == P_BRAKE) m_phase = P_IDLE;
                    else begin m_phase = P_BRAKE; m_rem = BRAKE; end
                end
            end else if (m_run == STABLE && m_armed) begin
                m_armed = 1'b0;
                if (s == 3'b001)      begin m_phase = P_FWD;  m_rem = FWD;  ack_now = 1'b1; end
                else if (s == 3'b010) begin m_phase = P_TURN; m_rem = TURN; ack_now = 1'b1; end
                else                  err_now = 1'b1;
            end
        end
        h2 = h1; h1 = v; k++;
        #1;
        chk("motor_l", 32'(motor_l), 32'(e_ml));
        chk("motor_r", 32'(motor_r), 32'(e_mr));
        chk("pwm_l",   32'(pwm_l),   32'(e_pl));
        chk("pwm_r",   32'(pwm_r),   32'(e_pr));
        chk("state_o", 32'(state_o), 32'(e_st));
        chk("busy",    32'(busy),    32'(e_st != 2'b00));
        chk("cmd_ack", 32'(cmd_ack), 32'(ack_now));
        chk("cmd_err", 32'(cmd_err), 32'(err_now));
        if (cmd_ack === 1'b1) n_ack++;
        if (cmd_err === 1'b1) n_err++;
        if (busy === 1'b1) n_busy++;
        if (state_o === 2'b01) n_fwd++;
        if (state_o === 2'b10) n_turn++;
        if (state_o === 2'b11) n_brake++;
    endtask

    task automatic hold(input logic [2:0] v, input int ticks);
        for (int i = 0; i < ticks * TICK_DIV; i++) step(v);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 chk_zero(tag);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        reset = 1'b1;

        // forward run held long: single ack, 5 ticks FWD, 2 ticks BRAKE
        hold(3'b000, 2);
        clr_counts();
        hold(3'b001, 20);
        chk("fwd_acks", 32'(n_ack), 32'd1);
        chk("fwd_len", 32'(n_fwd), 32'(FWD * TICK_DIV));
        chk("fwd_brake_len", 32'(n_brake), 32'(BRAKE * TICK_DIV));
        hold(3'b000, 3);

        // 010 for 2 ticks is too short; 3 ticks gives a turn
        clr_counts();
        hold(3'b010, 2);
        hold(3'b000, 3);
        chk("short_acks", 32'(n_ack), 32'd0);
        chk("short_busy", 32'(n_busy), 32'd0);
        clr_counts();
        hold(3'b010, 3);
        hold(3'b000, 8);
        chk("turn_acks", 32'(n_ack), 32'd1);
        chk("turn_len", 32'(n_turn), 32'(TURN * TICK_DIV));
        chk("turn_brake_len", 32'(n_brake), 32'(BRAKE * TICK_DIV));

        // qualify while busy is dropped; held code needs a zero before re-acceptance
        clr_counts();
        hold(3'b001, 4);
        hold(3'b000, 1);
        hold(3'b010, 20);
        chk("busy_drop_acks", 32'(n_ack), 32'd1);
        chk("busy_drop_turn", 32'(n_turn), 32'd0);
        hold(3'b000, 2);
        hold(3'b010, 3);
        hold(3'b000, 8);
        chk("rearm_acks", 32'(n_ack), 32'd2);

        // illegal code: error pulse, no motion, disarmed until zero
        clr_counts();
        hold(3'b011, 3);
        hold(3'b001, 4);
        chk("illegal_err", 32'(n_err), 32'd1);
        chk("illegal_acks", 32'(n_ack), 32'd0);
        chk("illegal_busy", 32'(n_busy), 32'd0);
        hold(3'b000, 1);
        hold(3'b001, 4);
        hold(3'b000, 10);
        chk("after_illegal_acks", 32'(n_ack), 32'd1);

        // reset in the middle of a forward run
        hold(3'b001, 6);
        do_reset("midfwd");
        clr_counts();
        hold(3'b001, 3);
        hold(3'b000, 10);
        chk("post_reset_acks", 32'(n_ack), 32'd1);

        // glitchy command never qualifies
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            hold(3'b001, 1);
            hold(3'b000, 1);
        end
        chk("glitch_acks", 32'(n_ack), 32'd0);
        chk("glitch_busy", 32'(n_busy), 32'd0);

        // random holds against the model
        for (int i = 0; i < 80; i++) begin
            logic [2:0] v;
            int n;
            case ($urandom_range(0, 4))
                0: v = 3'b000;
                1: v = 3'b001;
                2: v = 3'b010;
                3: v = 3'b000;
                default: v = 3'($urandom_range(0, 7));
            endcase
            n = $urandom_range(1, 24);
            for (int j = 0; j < n; j++) step(v);
        end
        hold(3'b000, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
